// File: rtl/fetch_mem_adapter_pkg.sv
// Shared types and constants for the instruction-fetch-to-16-bit-bus adapter.
package fetch_mem_adapter_pkg;

  // Codebase-wide widths: PC / word width and instruction width.
  localparam int RW     = 16;
  localparam int I_SIZE = 32;
  localparam int BUS_W  = 16;

  // Low bit of the bus word address selects the instruction half.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Bus word address of one instruction half; PC 16'hFFFF wraps naturally.
  function automatic logic [RW:0] bus_addr(input logic [RW-1:0] pc, input logic half);
    return {pc, half};
  endfunction

endpackage

// File: rtl/fetch_mem_adapter_if.sv
// Fetch-side and memory-side signals of the adapter.
// Handshakes: the fetch stage holds i_req_active with i_req_addr; the adapter
// samples them only in IDLE and answers with a one-cycle o_req_data_valid pulse.
// On the bus, o_mem_req acts as valid and i_mem_ack as ready: o_mem_req and
// o_mem_addr hold steady until a cycle with i_mem_ack=1, which completes the
// beat with i_mem_data valid in that same cycle.
interface fetch_mem_adapter_if;
  import fetch_mem_adapter_pkg::*;

  logic [RW-1:0]     i_req_addr;
  logic              i_req_active;
  logic [I_SIZE-1:0] o_req_data;
  logic              o_req_data_valid;
  logic              i_invalidate;
  logic              o_mem_req;
  logic [RW:0]       o_mem_addr;
  logic              i_mem_ack;
  logic [BUS_W-1:0]  i_mem_data;

  // Environment view: fetch stage plus memory.
  modport master (
    output i_req_addr, i_req_active, i_invalidate, i_mem_ack, i_mem_data,
    input  o_req_data, o_req_data_valid, o_mem_req, o_mem_addr
  );

  // Adapter view.
  modport slave (
    input  i_req_addr, i_req_active, i_invalidate, i_mem_ack, i_mem_data,
    output o_req_data, o_req_data_valid, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/fetch_line_buf.sv
// Single-entry instruction line buffer: tag, data and valid bit with a
// combinational hit output. Invalidate wins over a same-cycle write.
module fetch_line_buf
  import fetch_mem_adapter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RW-1:0]     lookup_tag,
  output logic              hit,
  output logic [I_SIZE-1:0] rd_data,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_tag,
  input  logic [I_SIZE-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              inv
);
  logic [RW-1:0]     tag_q;
  logic [I_SIZE-1:0] data_q;
  logic              valid_q;

  // Line storage: fill writes tag/data, valid follows the fill unless invalidated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        tag_q  <= wr_tag;
        data_q <= wr_data;
      end
      if (inv)        valid_q <= 1'b0;
      else if (wr_en) valid_q <= wr_valid;
    end
  end

  assign hit     = valid_q && (tag_q == lookup_tag);
  assign rd_data = data_q;
endmodule

// File: rtl/fetch_mem_adapter.sv
// Turns 32-bit instruction fetches into two 16-bit bus reads (low half first),
// with a one-line buffer that serves repeated fetches without bus traffic.
module fetch_mem_adapter
  import fetch_mem_adapter_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  fetch_mem_adapter_if.slave  bus,
  output state_t              dbg_state
);
  state_t            state_q, state_d;
  logic [RW-1:0]     pc_q;
  logic [BUS_W-1:0]  lo_q;
  logic [I_SIZE-1:0] data_q;
  logic              mem_req_q;
  logic [RW:0]       mem_addr_q;
  logic              pend_q;

  logic              take_hit, take_miss, lo_done, hi_done;
  logic              line_hit;
  logic [I_SIZE-1:0] line_data;

  fetch_line_buf u_line_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .lookup_tag (bus.i_req_addr),
    .hit        (line_hit),
    .rd_data    (line_data),
    .wr_en      (hi_done),
    .wr_tag     (pc_q),
    .wr_data    ({bus.i_mem_data, lo_q}),
    .wr_valid   (!pend_q),
    .inv        (bus.i_invalidate)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and step strobes; an invalidate during the hit check forces a miss.
  always_comb begin
    state_d   = state_q;
    take_hit  = 1'b0;
    take_miss = 1'b0;
    lo_done   = 1'b0;
    hi_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_active) begin
          if (line_hit && !bus.i_invalidate) begin
            take_hit = 1'b1;
            state_d  = ST_RESP;
          end else begin
            take_miss = 1'b1;
            state_d   = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (bus.i_mem_ack) begin
          lo_done = 1'b1;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (bus.i_mem_ack) begin
          hi_done = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latched PC, bus request/address, assembled instruction, pending invalidate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= '0;
      lo_q       <= '0;
      data_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (take_miss) begin
        pc_q       <= bus.i_req_addr;
        mem_req_q  <= 1'b1;
        mem_addr_q <= bus_addr(bus.i_req_addr, HALF_LO);
      end
      if (lo_done) begin
        lo_q       <= bus.i_mem_data;
        mem_addr_q <= bus_addr(pc_q, HALF_HI);
      end
      if (hi_done) begin
        mem_req_q <= 1'b0;
        data_q    <= {bus.i_mem_data, lo_q};
      end
      if (take_hit) data_q <= line_data;
      if (state_q == ST_RESP)
        pend_q <= 1'b0;
      else if (bus.i_invalidate && (state_q == ST_LO || state_q == ST_HI))
        pend_q <= 1'b1;
    end
  end

  assign bus.o_req_data       = data_q;
  assign bus.o_req_data_valid = (state_q == ST_RESP);
  assign bus.o_mem_req        = mem_req_q;
  assign bus.o_mem_addr       = mem_addr_q;
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_fetch_mem_adapter.sv
// Directed bench for fetch_mem_adapter: misses, hits, wait states, invalidates,
// reset mid-fill and PC wrap. Inputs change 1ns after the rising edge, and
// outputs are checked at that point, reflecting the edge just taken.
module tb_fetch_mem_adapter;
  import fetch_mem_adapter_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     n_cmp  = 0;
  int     n_err  = 0;
  int     pulses = 0;

  fetch_mem_adapter_if bus ();

  fetch_mem_adapter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count valid pulses seen on the falling edge.
  always @(negedge clk) if (bus.o_req_data_valid === 1'b1) pulses++;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the FSM state, bus request/address and the valid strobe together.
  task automatic check_out(input string tag, input state_t st, input logic req,
                           input logic [16:0] addr, input logic vld);
    check({tag, ".state"}, 64'(dbg_state), 64'(st));
    check({tag, ".mem_req"}, 64'(bus.o_mem_req), 64'(req));
    if (req) check({tag, ".mem_addr"}, 64'(bus.o_mem_addr), 64'(addr));
    check({tag, ".valid"}, 64'(bus.o_req_data_valid), 64'(vld));
  endtask

  // Full miss with zero-wait acks; call while the DUT is in IDLE.
  task automatic miss_fill(input string tag, input logic [15:0] addr,
                           input logic [15:0] lo, input logic [15:0] hi);
    bus.i_req_addr = addr; bus.i_req_active = 1'b1;
    step();
    check_out({tag, ".lo"}, ST_LO, 1'b1, {addr, 1'b0}, 1'b0);
    bus.i_req_active = 1'b0;
    bus.i_mem_ack = 1'b1; bus.i_mem_data = lo;
    step();
    check_out({tag, ".hi"}, ST_HI, 1'b1, {addr, 1'b1}, 1'b0);
    bus.i_mem_data = hi;
    step();
    check_out({tag, ".resp"}, ST_RESP, 1'b0, 17'h0, 1'b1);
    check({tag, ".data"}, 64'(bus.o_req_data), 64'({hi, lo}));
    bus.i_mem_ack = 1'b0; bus.i_mem_data = 16'h0;
    step();
    check_out({tag, ".idle"}, ST_IDLE, 1'b0, 17'h0, 1'b0);
    check({tag, ".hold"}, 64'(bus.o_req_data), 64'({hi, lo}));
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1;
    bus.i_req_addr = 16'h0; bus.i_req_active = 1'b0; bus.i_invalidate = 1'b0;
    bus.i_mem_ack = 1'b0; bus.i_mem_data = 16'h0;
    step(); step();
    check_out("reset", ST_IDLE, 1'b0, 17'h0, 1'b0);
    check("reset.mem_addr", 64'(bus.o_mem_addr), 64'h0);
    check("reset.data", 64'(bus.o_req_data), 64'h0);
    rst = 1'b0;
    step();

    // Miss at PC 4: bus words 8 then 9, instruction 32'h0010000E.
    miss_fill("miss4", 16'h0004, 16'h000E, 16'h0010);

    // Same PC again: served from the buffer.
    bus.i_req_addr = 16'h0004; bus.i_req_active = 1'b1;
    step();
    check_out("hit4", ST_RESP, 1'b0, 17'h0, 1'b1);
    check("hit4.data", 64'(bus.o_req_data), 64'h0010000E);
    bus.i_req_active = 1'b0;
    step();
    check_out("hit4.idle", ST_IDLE, 1'b0, 17'h0, 1'b0);

    // Stray ack in IDLE does nothing.
    bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'hDEAD;
    step();
    check_out("stray_ack", ST_IDLE, 1'b0, 17'h0, 1'b0);
    bus.i_mem_ack = 1'b0;

    // Three wait cycles per beat; request inputs change but are ignored.
    bus.i_req_addr = 16'h0123; bus.i_req_active = 1'b1;
    step();
    bus.i_req_addr = 16'h7777; bus.i_req_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_out("wait.lo", ST_LO, 1'b1, 17'h00246, 1'b0);
      step();
    end
    check_out("wait.lo3", ST_LO, 1'b1, 17'h00246, 1'b0);
    bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'hA5A5;
    step();
    bus.i_mem_ack = 1'b0; bus.i_mem_data = 16'h0;
    for (int i = 0; i < 3; i++) begin
      check_out("wait.hi", ST_HI, 1'b1, 17'h00247, 1'b0);
      step();
    end
    bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h5A5A;
    step();
    check_out("wait.resp", ST_RESP, 1'b0, 17'h0, 1'b1);
    check("wait.data", 64'(bus.o_req_data), 64'h5A5AA5A5);
    bus.i_mem_ack = 1'b0;
    step();
    check_out("wait.after", ST_IDLE, 1'b0, 17'h0, 1'b0);

    // Invalidate during HI: fill completes but the line stays invalid.
    bus.i_req_addr = 16'h0200; bus.i_req_active = 1'b1;
    step();
    check_out("invhi.lo", ST_LO, 1'b1, 17'h00400, 1'b0);
    bus.i_req_active = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h1111;
    step();
    bus.i_mem_ack = 1'b0; bus.i_invalidate = 1'b1;
    step();
    check_out("invhi.hi", ST_HI, 1'b1, 17'h00401, 1'b0);
    bus.i_invalidate = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h2222;
    step();
    check_out("invhi.resp", ST_RESP, 1'b0, 17'h0, 1'b1);
    check("invhi.data", 64'(bus.o_req_data), 64'h22221111);
    bus.i_mem_ack = 1'b0;
    step();
    miss_fill("refill", 16'h0200, 16'h3333, 16'h4444);

    // Invalidate coinciding with a would-be hit forces a miss.
    bus.i_invalidate = 1'b1;
    bus.i_req_addr = 16'h0200; bus.i_req_active = 1'b1;
    step();
    check_out("invhit.lo", ST_LO, 1'b1, 17'h00400, 1'b0);
    bus.i_invalidate = 1'b0; bus.i_req_active = 1'b0;
    bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h5555;
    step();
    bus.i_mem_data = 16'h6666;
    step();
    check("invhit.data", 64'(bus.o_req_data), 64'h66665555);
    bus.i_mem_ack = 1'b0;
    step();
    bus.i_req_addr = 16'h0200; bus.i_req_active = 1'b1;
    step();
    check_out("hit200", ST_RESP, 1'b0, 17'h0, 1'b1);
    check("hit200.data", 64'(bus.o_req_data), 64'h66665555);
    bus.i_req_active = 1'b0;
    step();

    // Reset in LO with the ack arriving one cycle later.
    bus.i_req_addr = 16'h0300; bus.i_req_active = 1'b1;
    step();
    check_out("rstlo.lo", ST_LO, 1'b1, 17'h00600, 1'b0);
    bus.i_req_active = 1'b0; rst = 1'b1;
    step();
    check_out("rstlo.rst", ST_IDLE, 1'b0, 17'h0, 1'b0);
    rst = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_data = 16'h9999;
    step();
    check_out("rstlo.late_ack", ST_IDLE, 1'b0, 17'h0, 1'b0);
    bus.i_mem_ack = 1'b0;
    step();
    miss_fill("post_rst", 16'h0200, 16'h7777, 16'h8888);

    // PC wrap, then an IDLE invalidate makes the same PC miss again.
    miss_fill("wrap", 16'hFFFF, 16'hBEEF, 16'hCAFE);
    bus.i_invalidate = 1'b1;
    step();
    bus.i_invalidate = 1'b0;
    miss_fill("inv_idle", 16'hFFFF, 16'h1234, 16'h5678);

    // One pulse per completed transaction: 2 + 1 + 4 + 1 + 2.
    check("pulse_count", 64'(pulses), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_mem_adapter.md
FETCH_MEM_ADAPTER -- requirements
Module: fetch_mem_adapter

Interface
REQ-001 Parameters: none; widths come from config.v: RW=16 (word/PC width) and I_SIZE=32 (instruction width).
REQ-002 i_clk  input  1  clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_addr  input  RW  instruction address (PC) from the fetch stage; sampled only in IDLE.
REQ-005 i_req_active  input  1  fetch stage requests the instruction at i_req_addr.
REQ-006 o_req_data  output  I_SIZE  fetched instruction; valid only while o_req_data_valid=1.
REQ-007 o_req_data_valid  output  1  single-cycle pulse marking o_req_data complete.
REQ-008 i_invalidate  input  1  clears the line buffer (self-modifying code, memory remap).
REQ-009 o_mem_req  output  1  bus read request; held until acknowledged.
REQ-010 o_mem_addr  output  RW+1  16-bit bus word address, {pc,1'b0} for the low half and {pc,1'b1} for the high half.
REQ-011 i_mem_ack  input  1  bus beat complete; i_mem_data is valid in the same cycle.
REQ-012 i_mem_data  input  16  bus read data.

Function
REQ-013 States are IDLE, LO, HI and RESP; only the transitions listed below exist.
REQ-014 IDLE with i_req_active=1 and a line hit (buffer valid, tag == i_req_addr): load o_req_data from the buffer and go to RESP; no bus access.
REQ-015 IDLE with i_req_active=1 and a miss: latch i_req_addr, assert o_mem_req with the low-half address, and go to LO.
REQ-016 LO on i_mem_ack: store i_mem_data into instr[15:0], drive the high-half address with o_mem_req still asserted, and go to HI.
REQ-017 HI on i_mem_ack: store i_mem_data into instr[31:16], deassert o_mem_req, and go to RESP; the tag, data and valid bit of the line buffer are written from the assembled instruction.
REQ-018 RESP: o_req_data_valid=1 for exactly this cycle, then go to IDLE unconditionally; no new request is sampled in RESP.
REQ-019 Latency: a hit gives valid 2 cycles after the request is sampled; a miss gives valid 1 cycle after the second ack; the minimum miss is 4 cycles with zero-wait acks.
REQ-020 o_req_data stays stable from the valid pulse until the next RESP entry.
REQ-021 Changes on i_req_addr or i_req_active while in LO/HI/RESP are ignored; the latched address is used.
REQ-022 Deassertion of i_req_active mid-transaction does not abort it; the transaction completes and pulses valid.
REQ-023 While o_mem_req=1, o_mem_addr stays stable; i_mem_ack in IDLE or RESP is ignored.
REQ-024 i_invalidate in IDLE/RESP clears the buffer's valid bit on the next edge.
REQ-025 i_invalidate during LO/HI sets a pending flag, so the completing fill writes data but leaves the buffer invalid; the pending flag clears on RESP.
REQ-026 i_invalidate coinciding with an IDLE hit check forces a miss for that request.
REQ-027 The address wraps: PC 16'hFFFF maps to bus addresses 17'h1FFFE and 17'h1FFFF; there is no carry into other logic.

Reset
REQ-028 On i_rst: the state goes to IDLE, and o_mem_req=0, o_mem_addr=0, o_req_data=0, o_req_data_valid=0, buffer valid=0, pending-invalidate=0.
REQ-029 Reset mid-transaction abandons the transaction immediately: no valid pulse, no buffer write, and a late ack is ignored.

Structure
REQ-030 The state encoding and the half-select localparams go in the shared package or defines with config.v; RW and I_SIZE are reused from config.v and not redefined.
REQ-031 One sub-module, fetch_line_buf, holds the tag, data and valid bit and provides a combinational hit output and a write/invalidate port.

Verification
REQ-032 Miss with zero-wait acks: req addr 16'h0004, data 16'h000E then 16'h0010 -> o_mem_addr 17'h00008 then 17'h00009, valid pulse with o_req_data=32'h0010000E 4 cycles after sampling.
REQ-033 Hit: repeat addr 16'h0004 after REQ-032 -> no o_mem_req, valid 2 cycles later with 32'h0010000E.
REQ-034 Wait states: 3-cycle ack delay per beat -> o_mem_req and o_mem_addr stable throughout; exactly one valid pulse.
REQ-035 Invalidate during HI, then re-request the same addr -> a second bus fill occurs (miss).
REQ-036 Reset asserted in LO with the ack arriving the next cycle -> no valid pulse, o_mem_req=0, and the next request misses.
REQ-037 Wrap: addr 16'hFFFF -> bus addresses 17'h1FFFE and 17'h1FFFF.
